imem_prog_loader: RTL and testbench

Writer side of the instruction-memory interface. It receives a framed byte stream over a valid/ready channel, assembles big-endian 32-bit instruction words, and writes them sequentially into the instruction memory that the datapath fetches from. It holds the processor via cpu_hold while a load is in progress, and verifies the frame with an XOR checksum.

---
 rtl/imem_prog_loader.sv | 188 ++++++++++++++++++
 tb/tb_imem_prog_loader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_prog_loader.sv
// Instruction-memory program loader: framed byte stream -> sequential 32-bit IMEM writes.
// Optional inter-byte timeout is built when IMEM_LOADER_TIMEOUT_EN is defined.
module imem_prog_loader #(
  parameter int          ADDR_W      = 4,
  parameter logic [7:0]  HDR_BYTE    = 8'hA5,
  parameter int          TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int LW    = ADDR_W + 1;
  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEN  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_CSUM = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  logic [2:0]        state_q, state_d;
  logic              rdy_q, rdy_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [LW-1:0]     words_q, words_d;
  logic [LW-1:0]     n_q, n_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [23:0]       asm_q, asm_d;
  logic [7:0]        csum_q, csum_d;
  logic              acc;
  logic              tmo_hit;

  assign acc = rx_valid & rdy_q;

`ifdef IMEM_LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          in_frame;

  assign in_frame = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
  assign tmo_hit  = in_frame && !acc && (tmo_q == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    tmo_d = '0;
    if (in_frame && !acc && !tmo_hit) tmo_d = tmo_q + TW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYC == 0);
  assign tmo_hit    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    rdy_d   = 1'b1;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    hold_d  = hold_q;
    done_d  = done_q;
    err_d   = err_q;
    words_d = words_q;
    n_d     = n_q;
    bcnt_d  = bcnt_q;
    asm_d   = asm_q;
    csum_d  = csum_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (acc && rx_data == HDR_BYTE) begin
          state_d = S_LEN;
          hold_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
          words_d = '0;
          csum_d  = '0;
          bcnt_d  = '0;
        end
      end
      S_LEN: begin
        if (acc) begin
          if (rx_data == 8'd0 || {24'd0, rx_data} > 32'(DEPTH)) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            n_d     = LW'(rx_data);
            words_d = '0;
            bcnt_d  = '0;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (acc) begin
          csum_d = csum_q ^ rx_data;
          asm_d  = {asm_q[15:0], rx_data};
          bcnt_d = bcnt_q + 2'd1;
          // Fourth byte completes a big-endian word; write strobe is registered.
          if (bcnt_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = words_q[ADDR_W-1:0];
            wdata_d = {asm_q, rx_data};
            words_d = words_q + LW'(1);
            if (words_q + LW'(1) == n_q) state_d = S_CSUM;
          end
        end
      end
      S_CSUM: begin
        if (acc) begin
          if (rx_data == csum_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (tmo_hit) begin
      state_d = S_ERR;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      rdy_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      words_q <= '0;
      n_q     <= '0;
      bcnt_q  <= '0;
      asm_q   <= '0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
      words_q <= words_d;
      n_q     <= n_d;
      bcnt_q  <= bcnt_d;
      asm_q   <= asm_d;
      csum_q  <= csum_d;
    end
  end

  assign rx_ready     = rdy_q;
  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign cpu_hold     = hold_q;
  assign load_done    = done_q;
  assign load_err     = err_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_prog_loader.sv
// Bench for imem_prog_loader: frame table, hand-written timing/reset sequences, random frames vs model.
module tb_imem_prog_loader;
  localparam int AW = 4;
`ifdef IMEM_LOADER_TIMEOUT_EN
  localparam int TCYC = 16;
`else
  localparam int TCYC = 1024;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    rx_data = 8'd0;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_hold;
  logic          load_done;
  logic          load_err;
  logic [AW:0]   words_loaded;

  imem_prog_loader #(.ADDR_W(AW), .HDR_BYTE(8'hA5), .TIMEOUT_CYC(TCYC)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_hold(cpu_hold),
    .load_done(load_done), .load_err(load_err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int excl  = 0;
  logic [AW-1:0] wa[$];
  logic [31:0]   wd[$];

  always @(posedge clk) begin
    #1;
    if (imem_we === 1'b1) begin
      wa.push_back(imem_addr);
      wd.push_back(imem_wdata);
    end
    if (load_done === 1'b1 && load_err === 1'b1) excl++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_status(input string nm, input bit d, input bit e, input bit h, input int w);
    chk({nm, ".done"}, 32'(load_done), 32'(d));
    chk({nm, ".err"}, 32'(load_err), 32'(e));
    chk({nm, ".hold"}, 32'(cpu_hold), 32'(h));
    chk({nm, ".words"}, 32'(words_loaded), 32'(w));
  endtask

  typedef struct {
    string       name;
    logic [95:0] by;
    int          nb;
    bit          done;
    bit          err;
    bit          hold;
    int          words;
    int          nwr;
    logic [31:0] fdata;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [7:0] p[64];
    logic [7:0] b;
    logic [7:0] cs;
    logic [7:0] csb;
    logic [31:0] ew;
    int n, kind, ng;
    bit gdone;

    tbl[0] = '{"single",   96'hA5_01_00_00_0D_10_1D, 7, 1, 0, 0, 1, 1, 32'h0000_0D10};
    tbl[1] = '{"two",      96'hA5_02_00_00_0D_10_00_00_4D_11_41, 11, 1, 0, 0, 2, 2, 32'h0000_0D10};
    tbl[2] = '{"badcsum",  96'hA5_01_00_00_0D_10_00, 7, 0, 1, 1, 1, 1, 32'h0000_0D10};
    tbl[3] = '{"recover",  96'hA5_01_12_34_56_78_08, 7, 1, 0, 0, 1, 1, 32'h1234_5678};
    tbl[4] = '{"len0",     96'hA5_00, 2, 0, 1, 1, 0, 0, 32'h0};
    tbl[5] = '{"len17",    96'hA5_11, 2, 0, 1, 1, 0, 0, 32'h0};
    tbl[6] = '{"hdrdata",  96'hA5_01_A5_A5_00_01_01, 7, 1, 0, 0, 1, 1, 32'hA5A5_0001};
    tbl[7] = '{"garbage",  96'h3C_FF, 2, 1, 0, 0, 1, 0, 32'h0};

    // Reset state
    #2;
    chk("rst.ready", 32'(rx_ready), 32'd0);
    chk("rst.we", 32'(imem_we), 32'd0);
    chk("rst.addr", 32'(imem_addr), 32'd0);
    chk("rst.wdata", imem_wdata, 32'd0);
    chk_status("rst", 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    idle(1);
    chk("ready", 32'(rx_ready), 32'd1);

    // Table-driven frames
    for (int v = 0; v < 8; v++) begin
      wa.delete();
      wd.delete();
      for (int i = 0; i < tbl[v].nb; i++) send(tbl[v].by[8*(tbl[v].nb-1-i) +: 8]);
      idle(2);
      chk_status(tbl[v].name, tbl[v].done, tbl[v].err, tbl[v].hold, tbl[v].words);
      chk({tbl[v].name, ".nwr"}, 32'(wa.size()), 32'(tbl[v].nwr));
      for (int i = 0; i < wa.size() && i < tbl[v].nwr; i++)
        chk({tbl[v].name, ".addr"}, 32'(wa[i]), 32'(i));
      if (tbl[v].nwr > 0 && wd.size() > 0) chk({tbl[v].name, ".data0"}, wd[0], tbl[v].fdata);
    end

    // Write strobe timing, back-to-back bytes
    wa.delete();
    wd.delete();
    send(8'hA5);
    chk("t.hold", 32'(cpu_hold), 32'd1);
    chk("t.done_clr", 32'(load_done), 32'd0);
    send(8'h02); send(8'h00); send(8'h00); send(8'h0D);
    chk("t.we_early", 32'(imem_we), 32'd0);
    send(8'h10);
    chk("t.we0", 32'(imem_we), 32'd1);
    chk("t.addr0", 32'(imem_addr), 32'd0);
    chk("t.data0", imem_wdata, 32'h0000_0D10);
    chk("t.words0", 32'(words_loaded), 32'd1);
    send(8'h00);
    chk("t.we_pulse", 32'(imem_we), 32'd0);
    send(8'h00); send(8'h4D); send(8'h11);
    chk("t.we1", 32'(imem_we), 32'd1);
    chk("t.addr1", 32'(imem_addr), 32'd1);
    chk("t.data1", imem_wdata, 32'h0000_4D11);
    send(8'h41);
    chk("t.done", 32'(load_done), 32'd1);
    chk("t.hold_rel", 32'(cpu_hold), 32'd0);
    idle(1);

    // Reset mid-frame
    wa.delete();
    wd.delete();
    send(8'hA5); send(8'h01); send(8'h00); send(8'h00);
    chk("mr.hold_pre", 32'(cpu_hold), 32'd1);
    @(negedge clk);
    rx_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("mr.ready", 32'(rx_ready), 32'd0);
    chk_status("mr", 0, 0, 0, 0);
    chk("mr.wdata", imem_wdata, 32'd0);
    idle(2);
    @(negedge clk);
    reset = 1'b1;
    send(8'h0D); send(8'h10);
    idle(2);
    chk("mr.nowrite", 32'(wa.size()), 32'd0);
    chk("mr.ready_after", 32'(rx_ready), 32'd1);
    chk_status("mr.after", 0, 0, 0, 0);

    // Stalled frame: timeout or indefinite wait
    wa.delete();
    wd.delete();
    send(8'hA5); send(8'h01); send(8'h00);
`ifdef IMEM_LOADER_TIMEOUT_EN
    idle(15);
    chk("to.not_yet", 32'(load_err), 32'd0);
    idle(1);
    chk_status("to", 0, 1, 1, 0);
    chk("to.nowrite", 32'(wa.size()), 32'd0);
`else
    idle(20);
    chk_status("stall", 0, 0, 1, 0);
    send(8'h00); send(8'h0D); send(8'h10); send(8'h1D);
    idle(1);
    chk_status("stall.resume", 1, 0, 0, 1);
    chk("stall.nwr", 32'(wa.size()), 32'd1);
`endif

    // Random frames vs model
    for (int it = 0; it < 30; it++) begin
      wa.delete();
      wd.delete();
      ng = $urandom_range(0, 2);
      for (int g = 0; g < ng; g++) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h3C;
        send(b);
      end
      kind = (it == 0) ? 5 : $urandom_range(0, 9);
      if (kind == 0) begin
        n = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(17, 255);
        send(8'hA5);
        send(8'(n));
        idle(2);
        chk_status("rnd.badlen", 0, 1, 1, 0);
        chk("rnd.badlen.nwr", 32'(wa.size()), 32'd0);
      end else begin
        n = (it == 0) ? 16 : $urandom_range(1, 16);
        cs = 8'd0;
        send(8'hA5);
        send(8'(n));
        for (int i = 0; i < 4 * n; i++) begin
          p[i] = 8'($urandom);
          cs = cs ^ p[i];
          send(p[i]);
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        csb = (kind == 1) ? (cs ^ 8'($urandom_range(1, 255))) : cs;
        send(csb);
        idle(2);
        gdone = (kind != 1);
        chk_status("rnd", gdone, !gdone, !gdone, n);
        chk("rnd.nwr", 32'(wa.size()), 32'(n));
        for (int i = 0; i < n && i < wa.size(); i++) begin
          ew = {p[4*i], p[4*i+1], p[4*i+2], p[4*i+3]};
          chk("rnd.addr", 32'(wa[i]), 32'(i));
          chk("rnd.data", wd[i], ew);
        end
      end
    end

    chk("mutex", 32'(excl), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
